// File: rtl/envelope_detector_pkg.sv
// rtl/envelope_detector_pkg.sv - shared states and constants for the envelope detector
package envelope_detector_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int PIPE_LATENCY = 3;

  // beta = 3/8 realised as (mn >> 2) + (mn >> 3)
  localparam int BETA_SHIFT_A = 2;
  localparam int BETA_SHIFT_B = 3;

endpackage

// File: rtl/envelope_detector_if.sv
// rtl/envelope_detector_if.sv - sample stream and result bundle of the envelope detector
interface envelope_detector_if #(
  parameter int DATA_WIDTH  = 18,
  parameter int INDEX_WIDTH = 16
);
  logic                            enable;
  logic                            stopDataInFlag;
  logic signed [2*DATA_WIDTH-1:0]  dataInRe;
  logic signed [2*DATA_WIDTH-1:0]  dataInIm;
  logic        [2*DATA_WIDTH:0]    dataOut;
  logic                            dataOutValid;
  logic        [2*DATA_WIDTH:0]    peakValue;
  logic        [INDEX_WIDTH-1:0]   peakIndex;
  logic                            doneFlag;

  modport master (
    output enable, stopDataInFlag, dataInRe, dataInIm,
    input  dataOut, dataOutValid, peakValue, peakIndex, doneFlag
  );

  modport slave (
    input  enable, stopDataInFlag, dataInRe, dataInIm,
    output dataOut, dataOutValid, peakValue, peakIndex, doneFlag
  );
endinterface

// File: rtl/envelope_detector_abs_max_min.sv
// rtl/envelope_detector_abs_max_min.sv - pipeline stages 1-2: registered |Re|/|Im| then max/min
module envelope_detector_abs_max_min #(
  parameter int DATA_WIDTH = 18
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic signed [2*DATA_WIDTH-1:0] re,
  input  logic signed [2*DATA_WIDTH-1:0] im,
  output logic        [2*DATA_WIDTH-1:0] mx,
  output logic        [2*DATA_WIDTH-1:0] mn
);

  localparam int W = 2*DATA_WIDTH;

  logic [W-1:0] re_u, im_u;
  logic [W-1:0] abs_re, abs_im;

  assign re_u = re;
  assign im_u = im;

  // Unsigned result lets the most negative input map to 2^(W-1) exactly
  always_ff @(posedge clock) begin
    if (reset) begin
      abs_re <= '0;
      abs_im <= '0;
    end else begin
      abs_re <= re_u[W-1] ? (~re_u + 1'b1) : re_u;
      abs_im <= im_u[W-1] ? (~im_u + 1'b1) : im_u;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      mx <= '0;
      mn <= '0;
    end else if (abs_re >= abs_im) begin
      mx <= abs_re;
      mn <= abs_im;
    end else begin
      mx <= abs_im;
      mn <= abs_re;
    end
  end

endmodule

// File: rtl/envelope_detector.sv
// rtl/envelope_detector.sv - alpha-max-beta-min envelope detector; ENVELOPE_PEAK_DETECT_EN adds peak/index tracking
module envelope_detector
  import envelope_detector_pkg::*;
#(
  parameter int DATA_WIDTH  = 18,
  parameter int INDEX_WIDTH = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  envelope_detector_if.slave   bus
);

  localparam int W = 2*DATA_WIDTH;

  state_t                  state, state_next;
  logic                    accept;
  logic [1:0]              drain_cnt;
  logic [W-1:0]            mx, mn;
  logic [W:0]              sum;
  logic [W:0]              data_q;
  logic [PIPE_LATENCY-1:0] valid_pipe;

  envelope_detector_abs_max_min #(.DATA_WIDTH(DATA_WIDTH)) u_abs_max_min (
    .clock (clock),
    .reset (reset),
    .re    (bus.dataInRe),
    .im    (bus.dataInIm),
    .mx    (mx),
    .mn    (mn)
  );

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    case (state)
      IDLE:  if (bus.enable) state_next = RUN;
      RUN: begin
        if (bus.stopDataInFlag) state_next = DRAIN;
        else                    accept     = 1'b1;
      end
      DRAIN: if (drain_cnt == 2'(PIPE_LATENCY-1)) state_next = DONE;
      DONE:  if (!bus.enable) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      drain_cnt <= '0;
    end else begin
      state     <= state_next;
      drain_cnt <= (state == DRAIN) ? drain_cnt + 2'd1 : 2'd0;
    end
  end

  assign sum = {1'b0, mx} + {1'b0, (mn >> BETA_SHIFT_A)} + {1'b0, (mn >> BETA_SHIFT_B)};

  // dataOut is forced to zero whenever it is not a valid result
  always_ff @(posedge clock) begin
    if (reset) begin
      valid_pipe <= '0;
      data_q     <= '0;
    end else begin
      valid_pipe <= {valid_pipe[PIPE_LATENCY-2:0], accept};
      data_q     <= valid_pipe[PIPE_LATENCY-2] ? sum : '0;
    end
  end

  assign bus.dataOut      = data_q;
  assign bus.dataOutValid = valid_pipe[PIPE_LATENCY-1];
  assign bus.doneFlag     = (state == DONE);

`ifdef ENVELOPE_PEAK_DETECT_EN
  logic [INDEX_WIDTH-1:0]                    sample_cnt;
  logic [PIPE_LATENCY-1:0][INDEX_WIDTH-1:0]  idx_pipe;
  logic [W:0]                                peak_value;
  logic [INDEX_WIDTH-1:0]                    peak_index;

  // Each sample's index travels alongside it so the peak sees the matching index
  always_ff @(posedge clock) begin
    if (reset) begin
      sample_cnt <= '0;
      idx_pipe   <= '0;
      peak_value <= '0;
      peak_index <= '0;
    end else begin
      if (state == IDLE)
        sample_cnt <= '0;
      else if (accept && (sample_cnt != '1))
        sample_cnt <= sample_cnt + 1'b1;
      idx_pipe <= {idx_pipe[PIPE_LATENCY-2:0], sample_cnt};
      if ((state == IDLE) || (state_next == IDLE)) begin
        peak_value <= '0;
        peak_index <= '0;
      end else if (bus.dataOutValid && (data_q > peak_value)) begin
        peak_value <= data_q;
        peak_index <= idx_pipe[PIPE_LATENCY-1];
      end
    end
  end

  assign bus.peakValue = peak_value;
  assign bus.peakIndex = peak_index;
`else
  assign bus.peakValue = '0;
  assign bus.peakIndex = {INDEX_WIDTH{1'b0}};
`endif

endmodule

// File: tb/tb_envelope_detector.sv
// tb/tb_envelope_detector.sv - directed-vector bench for envelope_detector
module tb_envelope_detector;

  localparam int DW = 18;
  localparam int IW = 16;
  localparam int W  = 2*DW;

`ifdef ENVELOPE_PEAK_DETECT_EN
  localparam bit PEAK_EN = 1'b1;
`else
  localparam bit PEAK_EN = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset;

  envelope_detector_if #(.DATA_WIDTH(DW), .INDEX_WIDTH(IW)) bus ();

  envelope_detector #(.DATA_WIDTH(DW), .INDEX_WIDTH(IW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  int n_vec  = 0;
  int n_miss = 0;

  logic signed [W-1:0] s_re  [8];
  logic signed [W-1:0] s_im  [8];
  logic        [W:0]   s_exp [8];
  int                  s_n;

  task automatic check_vec(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic signed [W-1:0] re, input logic signed [W-1:0] im, input logic stop);
    bus.dataInRe       = re;
    bus.dataInIm       = im;
    bus.stopDataInFlag = stop;
  endtask

  // Streams s_re/s_im, stops with a junk sample, and checks each output in order
  task automatic run_stream(input logic signed [W-1:0] junk);
    for (int k = 0; k < s_n + 2; k++) begin
      if (k < s_n)       drive(s_re[k], s_im[k], 1'b0);
      else if (k == s_n) drive(junk, junk, 1'b1);
      else               drive('0, '0, 1'b0);
      tick();
      if (k >= 2) begin
        check_vec($sformatf("valid[%0d]", k-2), 64'(bus.dataOutValid), 64'd1);
        check_vec($sformatf("data[%0d]", k-2), 64'(bus.dataOut), 64'(s_exp[k-2]));
      end else begin
        check_vec($sformatf("early_valid[%0d]", k), 64'(bus.dataOutValid), 64'd0);
      end
    end
    tick();
    check_vec("drain_valid", 64'(bus.dataOutValid), 64'd0);
    check_vec("drain_done", 64'(bus.doneFlag), 64'd0);
    tick();
    check_vec("done", 64'(bus.doneFlag), 64'd1);
    check_vec("done_data", 64'(bus.dataOut), 64'd0);
  endtask

  initial begin
    reset      = 1'b1;
    bus.enable = 1'b0;
    drive('0, '0, 1'b0);
    tick();
    tick();
    check_vec("rst_data", 64'(bus.dataOut), 64'd0);
    check_vec("rst_valid", 64'(bus.dataOutValid), 64'd0);
    check_vec("rst_peak", 64'(bus.peakValue), 64'd0);
    check_vec("rst_index", 64'(bus.peakIndex), 64'd0);
    check_vec("rst_done", 64'(bus.doneFlag), 64'd0);

    // Stream 1: basic magnitudes, axis-aligned samples, most-negative corner
    reset = 1'b0;
    bus.enable = 1'b1;
    tick();
    s_n = 4;
    s_re[0] = -36'sd800;  s_im[0] = 36'sd600;   s_exp[0] = 37'd1025;
    s_re[1] = 36'sd1000;  s_im[1] = 36'sd0;     s_exp[1] = 37'd1000;
    s_re[2] = 36'sd0;     s_im[2] = -36'sd1000; s_exp[2] = 37'd1000;
    s_re[3] = {1'b1, 35'b0}; s_im[3] = {1'b1, 35'b0}; s_exp[3] = 37'd47244640256;
    run_stream(36'sd5);
    check_vec("s1_peak", 64'(bus.peakValue), PEAK_EN ? 64'd47244640256 : 64'd0);
    check_vec("s1_index", 64'(bus.peakIndex), PEAK_EN ? 64'd3 : 64'd0);

    // Hold enable in DONE, then drop it
    tick();
    tick();
    check_vec("hold_done", 64'(bus.doneFlag), 64'd1);
    check_vec("hold_peak", 64'(bus.peakValue), PEAK_EN ? 64'd47244640256 : 64'd0);
    bus.enable = 1'b0;
    tick();
    check_vec("idle_done", 64'(bus.doneFlag), 64'd0);
    check_vec("idle_peak", 64'(bus.peakValue), 64'd0);
    check_vec("idle_index", 64'(bus.peakIndex), 64'd0);
    bus.enable = 1'b1;
    tick();
    check_vec("rerun_peak", 64'(bus.peakValue), 64'd0);

    // Stream 2: peak tie keeps first index; large stop-cycle sample must be ignored
    bus.enable = 1'b0;
    s_n = 4;
    s_re[0] = 36'sd10; s_im[0] = 36'sd0;   s_exp[0] = 37'd10;
    s_re[1] = 36'sd50; s_im[1] = 36'sd0;   s_exp[1] = 37'd50;
    s_re[2] = 36'sd0;  s_im[2] = -36'sd50; s_exp[2] = 37'd50;
    s_re[3] = 36'sd20; s_im[3] = 36'sd0;   s_exp[3] = 37'd20;
    run_stream(36'sd100000);
    check_vec("s2_peak", 64'(bus.peakValue), PEAK_EN ? 64'd50 : 64'd0);
    check_vec("s2_index", 64'(bus.peakIndex), PEAK_EN ? 64'd1 : 64'd0);
    tick();
    check_vec("s2_idle", 64'(bus.doneFlag), 64'd0);

    // Reset with two samples in flight
    bus.enable = 1'b1;
    tick();
    bus.enable = 1'b0;
    drive(36'sd300, 36'sd400, 1'b0);
    tick();
    drive(36'sd700, 36'sd0, 1'b0);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    drive('0, '0, 1'b0);
    check_vec("mid_rst_data", 64'(bus.dataOut), 64'd0);
    check_vec("mid_rst_valid", 64'(bus.dataOutValid), 64'd0);
    check_vec("mid_rst_peak", 64'(bus.peakValue), 64'd0);
    check_vec("mid_rst_done", 64'(bus.doneFlag), 64'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check_vec($sformatf("post_rst_valid[%0d]", i), 64'(bus.dataOutValid), 64'd0);
    end

    // Counter saturation: a sample beyond 2^IW-1 shares the last index
    bus.enable = 1'b1;
    tick();
    drive('0, '0, 1'b0);
    for (int i = 0; i < (1 << IW); i++) tick();
    drive(36'sd7, 36'sd0, 1'b0);
    tick();
    drive('0, '0, 1'b1);
    tick();
    drive('0, '0, 1'b0);
    for (int i = 0; i < 3; i++) tick();
    check_vec("sat_done", 64'(bus.doneFlag), 64'd1);
    check_vec("sat_peak", 64'(bus.peakValue), PEAK_EN ? 64'd7 : 64'd0);
    check_vec("sat_index", 64'(bus.peakIndex), PEAK_EN ? 64'd65535 : 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
